accum_datapath_v2: RTL and testbench
====================================

Name: accum_datapath_v2

Overview:
Parametrised successor of the BIP accumulator datapath. It adds a 3-bit ALU opcode (arithmetic, logic and shift ops), a registered status-flag bank (Z/N/C/V), and an optional iterative multiplier with a Busy stall handshake toward the control unit. It sits between the control unit (SelA/SelB/WrAcc/Op) and data memory (Out_Data in, In_Data/Addr_DM out).

Parameters:
AB, 11, instruction operand/address width; must satisfy 1 <= AB <= DB.
DB, 16, data/accumulator width; must be >= 2.

Ports:
clk  in  1  rising-edge clock
Clear  in  1  reset; synchronous, active-high
SelA  in  2  ACC source: 00 ALU, 01 sign-extended Addr, 10 Out_Data, 11 hold
SelB  in  1  ALU B operand: 0 sign-extended Addr, 1 Out_Data
WrAcc  in  1  accumulator write enable
Op  in  3  ALU opcode
Addr  in  AB  operand/immediate from instruction
Out_Data  in  DB  data-memory read data
In_Data  out  DB  data-memory write data; equals ACC
Addr_DM  out  AB  data-memory address; combinational copy of Addr
Flags  out  4  {Z,N,C,V}, registered
Busy  out  1  multiplier running; control unit must stall

Behaviour:
- Reset (Clear=1 at an edge): ACC=0, Flags=0, Busy=0, FSM=IDLE. Clear has priority over every other input, including a running multiply (abort).
- Sign extension: replicate Addr[AB-1] into bits DB-1..AB.
- Opcodes, A=ACC, B=mux B:
  - 000 ADD A+B
  - 001 SUB A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL1 A<<1
  - 110 SAR1 arithmetic A>>1
  - 111 MUL (see Optional Feature)
- Single-cycle write: at an edge with WrAcc=1 and FSM=IDLE, ACC <= selected source. In_Data follows ACC with no further delay. SelA=11 never writes.
- Flag update rules:
  - Flags update only on an ALU write (SelA=00); loads (01/10) leave Flags unchanged.
  - Z = (result==0); N = result[DB-1].
  - ADD: C = carry-out, V = signed overflow.
  - SUB: computed as A+~B+1; C = carry-out (1 = no borrow), V = signed overflow.
  - Logic ops: C=0, V=0.
  - SHL1: C = A[DB-1], V=0. SAR1: C = A[0], V=0.
- FSM (MUL only): IDLE -> RUN on a WrAcc=1, SelA=00, Op=111 edge.
  - At that edge, ACC (multiplicand) and B (multiplier) are latched, the counter is set to 0, and Busy goes to 1.
  - RUN does one shift-add step per cycle for DB cycles.
  - On the DB-th edge after start: ACC <= low DB bits of the unsigned product, Z/N update, C=V=0, Busy=0, FSM=IDLE.
- While Busy=1, WrAcc/SelA/Op/SelB are ignored and ACC holds. Addr_DM still tracks Addr.
- Low DB bits of the product are identical for signed and unsigned operands; the high half is discarded with no overflow flag.

Optional Feature:
Macro DATAPATH_MUL_EN.
- Defined: Op=111 runs the iterative multiply described above; latency DB cycles, Busy asserted for those DB cycles.
- Undefined: Op=111 is a single-cycle PASSB (result=B, Z/N per result, C=V=0). Busy is tied 0, no FSM or multiplier logic is instantiated.

Decomposition:
- Shared package accum_dp_pkg holds:
  - opcode constants OP_ADD..OP_MUL
  - SelA codes SELA_ALU/SELA_IMM/SELA_MEM/SELA_HOLD
  - flag bit indices FLAG_Z/N/C/V
  - FSM state encodings ST_IDLE/ST_RUN
- One sub-module: accum_seq_mul.
  - Parametrised by DB; ports start, a, b, busy, done, product.
  - Compiled in only under DATAPATH_MUL_EN.
- The ALU stays inside accum_datapath_v2 as a combinational case on Op.

Test Plan:
1. Clear=1 for one cycle, then SelA=01, Addr=11'h7FF, WrAcc=1 -> In_Data=16'hFFFF, Flags=4'b0000 (a load does not touch flags).
2. ACC=16'h7FFF, Out_Data=16'h0001, SelB=1, Op=ADD, SelA=00 -> ACC=16'h8000, Flags Z=0, N=1, C=0, V=1.
3. ACC=16'h0005, Addr=11'd5, SelB=0, Op=SUB -> ACC=0, Z=1, N=0, C=1, V=0. Then SAR1 on ACC=16'h8001 -> 16'hC000, N=1, C=1.
4. MUL_EN defined: ACC=300, Out_Data=200, Op=MUL -> Busy=1 for exactly 16 cycles, then ACC=16'hEA60, N=1, C=V=0. A WrAcc=1 load issued while Busy=1 is ignored.
5. MUL_EN defined: start MUL, assert Clear on the 5th Busy cycle -> at that edge ACC=0, Flags=0, Busy=0, and a new MUL can start on the next cycle.
6. MUL_EN undefined: Op=111, SelB=1, Out_Data=16'h0000 -> ACC=0 in one cycle, Z=1, Busy stays 0.

Source files
------------

// File: rtl/accum_datapath_v2_pkg.sv
// Shared constants for the accumulator datapath: ALU opcodes, ACC source
// select codes, flag bit positions and multiplier FSM states.
package accum_dp_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SAR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] SELA_ALU  = 2'b00;
    localparam logic [1:0] SELA_IMM  = 2'b01;
    localparam logic [1:0] SELA_MEM  = 2'b10;
    localparam logic [1:0] SELA_HOLD = 2'b11;

    // Flags = {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mul_st_e;

endpackage

// File: rtl/accum_datapath_v2_if.sv
// Control/memory bus of the accumulator datapath.
// master: control unit + data memory side; slave: the datapath.
interface accum_datapath_v2_if #(
    parameter int AB = 11,
    parameter int DB = 16
) ();
    logic [1:0]    SelA;
    logic          SelB;
    logic          WrAcc;
    logic [2:0]    Op;
    logic [AB-1:0] Addr;
    logic [DB-1:0] Out_Data;
    logic [DB-1:0] In_Data;
    logic [AB-1:0] Addr_DM;
    logic [3:0]    Flags;
    logic          Busy;

    modport master (
        output SelA, SelB, WrAcc, Op, Addr, Out_Data,
        input  In_Data, Addr_DM, Flags, Busy
    );

    modport slave (
        input  SelA, SelB, WrAcc, Op, Addr, Out_Data,
        output In_Data, Addr_DM, Flags, Busy
    );
endinterface

// File: rtl/accum_datapath_v2_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, DB cycles.
// Ports: clk, Clear (sync reset), start, a, b -> busy, done, product.
// Only built when DATAPATH_MUL_EN is defined.
`ifdef DATAPATH_MUL_EN
module accum_seq_mul
    import accum_dp_pkg::*;
#(
    parameter int DB = 16
) (
    input  logic          clk,
    input  logic          Clear,
    input  logic          start,
    input  logic [DB-1:0] a,
    input  logic [DB-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DB-1:0] product
);
    localparam int CW = (DB > 1) ? $clog2(DB) : 1;

    mul_st_e       st_q;
    logic [CW-1:0] cnt_q;
    logic [DB-1:0] mcand_q;
    logic [DB-1:0] mplier_q;
    logic [DB-1:0] prod_q;
    logic          busy_q;
    logic [DB-1:0] step_d;

    // Partial product including the current step, so the final step
    // can be handed to the datapath on the same edge it completes.
    assign step_d  = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = (st_q == ST_RUN) && (cnt_q == CW'(DB - 1));
    assign product = step_d;
    assign busy    = busy_q;

    always_ff @(posedge clk) begin
        if (Clear) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (start) begin
                        st_q     <= ST_RUN;
                        cnt_q    <= '0;
                        mcand_q  <= a;
                        mplier_q <= b;
                        prod_q   <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    prod_q   <= step_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (done) begin
                        st_q   <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end
endmodule
`endif

// File: rtl/accum_datapath_v2.sv
// Accumulator datapath: ACC register, 8-op ALU, registered {Z,N,C,V}.
// Ports: clk, Clear (sync reset), bus (slave modport of the bus interface).
// DATAPATH_MUL_EN: Op=111 runs an iterative multiply with Busy stall;
// otherwise Op=111 is a single-cycle PASSB.
module accum_datapath_v2
    import accum_dp_pkg::*;
#(
    parameter int AB = 11,
    parameter int DB = 16
) (
    input logic clk,
    input logic Clear,
    accum_datapath_v2_if.slave bus
);
    logic [DB-1:0] acc_q, acc_d;
    logic [3:0]    flags_q, flags_d;
    logic [DB-1:0] ext;
    logic [DB-1:0] opb;
    logic [DB-1:0] res;
    logic [DB:0]   sum;
    logic          c_r, v_r;
    logic          busy;
    logic          start;
    logic          mul_done;
    logic [DB-1:0] mul_prod;

    always_comb begin
        ext = {DB{bus.Addr[AB-1]}};
        ext[AB-1:0] = bus.Addr;
    end

    assign opb = bus.SelB ? bus.Out_Data : ext;

    always_comb begin
        sum = '0;
        res = '0;
        c_r = 1'b0;
        v_r = 1'b0;
        unique case (bus.Op)
            OP_ADD: begin
                sum = {1'b0, acc_q} + {1'b0, opb};
                res = sum[DB-1:0];
                c_r = sum[DB];
                v_r = (acc_q[DB-1] == opb[DB-1]) &&
                      (res[DB-1] != acc_q[DB-1]);
            end
            OP_SUB: begin
                sum = {1'b0, acc_q} + {1'b0, ~opb} + 1'b1;
                res = sum[DB-1:0];
                c_r = sum[DB];
                v_r = (acc_q[DB-1] != opb[DB-1]) &&
                      (res[DB-1] != acc_q[DB-1]);
            end
            OP_AND: res = acc_q & opb;
            OP_OR:  res = acc_q | opb;
            OP_XOR: res = acc_q ^ opb;
            OP_SHL: begin
                res = {acc_q[DB-2:0], 1'b0};
                c_r = acc_q[DB-1];
            end
            OP_SAR: begin
                res = {acc_q[DB-1], acc_q[DB-1:1]};
                c_r = acc_q[0];
            end
            OP_MUL: res = opb;
            default: res = opb;
        endcase
    end

`ifdef DATAPATH_MUL_EN
    assign start = !busy && bus.WrAcc && (bus.SelA == SELA_ALU) &&
                   (bus.Op == OP_MUL);

    accum_seq_mul #(.DB(DB)) u_mul (
        .clk     (clk),
        .Clear   (Clear),
        .start   (start),
        .a       (acc_q),
        .b       (opb),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign start    = 1'b0;
    assign busy     = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        if (mul_done) begin
            acc_d   = mul_prod;
            flags_d = {mul_prod == '0, mul_prod[DB-1], 2'b00};
        end else if (bus.WrAcc && !busy && !start) begin
            unique case (bus.SelA)
                SELA_ALU: begin
                    acc_d   = res;
                    flags_d = {res == '0, res[DB-1], c_r, v_r};
                end
                SELA_IMM:  acc_d = ext;
                SELA_MEM:  acc_d = bus.Out_Data;
                SELA_HOLD: acc_d = acc_q;
                default:   acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Clear) begin
            acc_q   <= '0;
            flags_q <= '0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

    assign bus.In_Data = acc_q;
    assign bus.Addr_DM = bus.Addr;
    assign bus.Flags   = flags_q;
    assign bus.Busy    = busy;
endmodule

// File: tb/tb_accum_datapath_v2.sv
// Directed scoreboard bench for accum_datapath_v2.
// Multiply steps are built only when DATAPATH_MUL_EN is defined.
module tb_accum_datapath_v2;
    import accum_dp_pkg::*;

    typedef struct {
        logic [15:0] acc;
        logic [3:0]  fl;
        logic        busy;
        string       tag;
    } exp_t;

    logic clk;
    logic Clear;
    int   checks;
    int   errors;
    exp_t sb[$];

    accum_datapath_v2_if #(.AB(11), .DB(16)) bus ();

    accum_datapath_v2 #(.AB(11), .DB(16)) dut (
        .clk   (clk),
        .Clear (Clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(
        input logic        clr,
        input logic [1:0]  sela,
        input logic        selb,
        input logic        wr,
        input logic [2:0]  op,
        input logic [10:0] addr,
        input logic [15:0] od,
        input logic [15:0] e_acc,
        input logic [3:0]  e_fl,
        input logic        e_busy,
        input string       tag
    );
        exp_t e;
        exp_t g;
        Clear        = clr;
        bus.SelA     = sela;
        bus.SelB     = selb;
        bus.WrAcc    = wr;
        bus.Op       = op;
        bus.Addr     = addr;
        bus.Out_Data = od;
        e.acc  = e_acc;
        e.fl   = e_fl;
        e.busy = e_busy;
        e.tag  = tag;
        sb.push_back(e);
        #1;
        checks++;
        assert (bus.Addr_DM === addr) else begin
            errors++;
            $error("FAIL %s addr_dm got %h exp %h", tag, bus.Addr_DM, addr);
        end
        @(posedge clk);
        #1;
        g = sb.pop_front();
        checks++;
        assert (bus.In_Data === g.acc) else begin
            errors++;
            $error("FAIL %s acc got %h exp %h", g.tag, bus.In_Data, g.acc);
        end
        checks++;
        assert (bus.Flags === g.fl) else begin
            errors++;
            $error("FAIL %s flags got %b exp %b", g.tag, bus.Flags, g.fl);
        end
        checks++;
        assert (bus.Busy === g.busy) else begin
            errors++;
            $error("FAIL %s busy got %b exp %b", g.tag, bus.Busy, g.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Clear = 1'b1;
        bus.SelA = SELA_HOLD;
        bus.SelB = 1'b0;
        bus.WrAcc = 1'b0;
        bus.Op = OP_ADD;
        bus.Addr = '0;
        bus.Out_Data = '0;
        @(posedge clk);
        #1;
        step(1, SELA_ALU, 1, 1, OP_ADD, 11'h000, 16'h1234,
             16'h0000, 4'b0000, 0, "reset");
        step(0, SELA_IMM, 0, 1, OP_ADD, 11'h7FF, 16'h0000,
             16'hFFFF, 4'b0000, 0, "ld_imm_sext");
        step(0, SELA_MEM, 0, 1, OP_ADD, 11'h000, 16'h7FFF,
             16'h7FFF, 4'b0000, 0, "ld_mem");
        step(0, SELA_ALU, 1, 1, OP_ADD, 11'h000, 16'h0001,
             16'h8000, 4'b0101, 0, "add_ovf");
        step(0, SELA_IMM, 0, 1, OP_ADD, 11'd5, 16'h0000,
             16'h0005, 4'b0101, 0, "ld_keeps_flags");
        step(0, SELA_ALU, 0, 1, OP_SUB, 11'd5, 16'h0000,
             16'h0000, 4'b1010, 0, "sub_zero");
        step(0, SELA_MEM, 0, 1, OP_ADD, 11'd0, 16'h8001,
             16'h8001, 4'b1010, 0, "ld_8001");
        step(0, SELA_ALU, 0, 1, OP_SAR, 11'd0, 16'h0000,
             16'hC000, 4'b0110, 0, "sar1");
        step(0, SELA_ALU, 0, 1, OP_SHL, 11'd0, 16'h0000,
             16'h8000, 4'b0110, 0, "shl1");
        step(0, SELA_ALU, 1, 1, OP_AND, 11'd0, 16'h00FF,
             16'h0000, 4'b1000, 0, "and_zero");
        step(0, SELA_IMM, 0, 1, OP_ADD, 11'h7FF, 16'h0000,
             16'hFFFF, 4'b1000, 0, "ld_ffff");
        step(0, SELA_ALU, 1, 1, OP_XOR, 11'd0, 16'h0F0F,
             16'hF0F0, 4'b0100, 0, "xor");
        step(0, SELA_ALU, 0, 1, OP_OR, 11'd1, 16'h0000,
             16'hF0F1, 4'b0100, 0, "or_imm");
        step(0, SELA_IMM, 0, 1, OP_ADD, 11'h7FF, 16'h0000,
             16'hFFFF, 4'b0100, 0, "ld_ffff2");
        step(0, SELA_ALU, 0, 1, OP_ADD, 11'd1, 16'h0000,
             16'h0000, 4'b1010, 0, "add_carry");
        step(0, SELA_HOLD, 0, 1, OP_ADD, 11'd7, 16'h5555,
             16'h0000, 4'b1010, 0, "sela_hold");
        step(0, SELA_ALU, 1, 0, OP_ADD, 11'd7, 16'h5555,
             16'h0000, 4'b1010, 0, "wr_off");
        step(0, SELA_ALU, 0, 1, OP_SUB, 11'd1, 16'h0000,
             16'hFFFF, 4'b0100, 0, "sub_borrow");
`ifdef DATAPATH_MUL_EN
        step(0, SELA_ALU, 0, 1, OP_AND, 11'd0, 16'h0000,
             16'h0000, 4'b1000, 0, "and_imm0");
        step(0, SELA_MEM, 0, 1, OP_ADD, 11'd0, 16'd300,
             16'd300, 4'b1000, 0, "ld_300");
        step(0, SELA_ALU, 1, 1, OP_MUL, 11'd0, 16'd200,
             16'd300, 4'b1000, 1, "mul_start");
        for (int i = 2; i <= 16; i++) begin
            step(0, SELA_IMM, 0, 1, OP_ADD, 11'd9, 16'd0,
                 16'd300, 4'b1000, 1, "mul_busy_ld_ignored");
        end
        step(0, SELA_IMM, 0, 0, OP_ADD, 11'd9, 16'd0,
             16'hEA60, 4'b0100, 0, "mul_done");
        step(0, SELA_IMM, 0, 0, OP_ADD, 11'd9, 16'd0,
             16'hEA60, 4'b0100, 0, "mul_idle");
        step(0, SELA_IMM, 0, 1, OP_ADD, 11'd3, 16'd0,
             16'd3, 4'b0100, 0, "ld_3");
        step(0, SELA_ALU, 0, 1, OP_MUL, 11'd5, 16'd0,
             16'd3, 4'b0100, 1, "mul2_start");
        for (int i = 2; i <= 4; i++) begin
            step(0, SELA_ALU, 0, 1, OP_MUL, 11'd5, 16'd0,
                 16'd3, 4'b0100, 1, "mul2_busy");
        end
        step(1, SELA_ALU, 0, 1, OP_MUL, 11'd5, 16'd0,
             16'd0, 4'b0000, 0, "mul_abort");
        step(0, SELA_ALU, 1, 1, OP_MUL, 11'd0, 16'd9,
             16'd0, 4'b0000, 1, "mul3_start");
        for (int i = 2; i <= 16; i++) begin
            step(0, SELA_ALU, 0, 0, OP_ADD, 11'd0, 16'd0,
                 16'd0, 4'b0000, 1, "mul3_busy");
        end
        step(0, SELA_ALU, 0, 0, OP_ADD, 11'd0, 16'd0,
             16'd0, 4'b1000, 0, "mul3_done");
`else
        step(0, SELA_ALU, 1, 1, OP_MUL, 11'd0, 16'h1234,
             16'h1234, 4'b0000, 0, "passb");
        step(0, SELA_ALU, 1, 1, OP_MUL, 11'd0, 16'h0000,
             16'h0000, 4'b1000, 0, "passb_zero");
        step(0, SELA_ALU, 0, 1, OP_MUL, 11'h400, 16'h0000,
             16'hFC00, 4'b0100, 0, "passb_imm");
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
